// File: rtl/mult_div_seq.sv
// Multi-cycle signed MULT/DIV unit with HI/LO result registers (MIPS-style).
// Radix-2 iteration on operand magnitudes, followed by a single sign-fix cycle.
module mult_div_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              MDControl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              divZero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int ACC_W = 2 * DATA_W;
  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);
  localparam logic [5:0] CNT_MAX   = 6'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_op, r_sign_a, r_sign_b, r_dz;
  logic [DATA_W-1:0]     r_mag_a, r_mag_b;
  logic [ACC_W-1:0]      r_acc;
  logic [5:0]            r_cnt;
  logic [DATA_W-1:0]     r_hi, r_lo;

  logic                  w_div_zero;
  logic [DATA_W:0]       w_mul_sum;
  logic [DATA_W:0]       w_rem_sh;
  logic [DATA_W+1:0]     w_diff;
  logic                  w_ge;
  logic [ACC_W-1:0]      w_step;
  logic [ACC_W-1:0]      w_prod;
  logic [DATA_W-1:0]     w_fix_hi, w_fix_lo;

  // 0x80000000 negates to itself, which read as unsigned is the correct magnitude 2^31.
  function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] n;
    n = -x;
    return x[DATA_W-1] ? DATA_W'(n) : DATA_W'(x);
  endfunction

  function automatic logic [DATA_W-1:0] f_neg_w(input logic signed [DATA_W-1:0] x,
                                                input logic neg);
    logic signed [DATA_W-1:0] n;
    n = -x;
    return neg ? DATA_W'(n) : DATA_W'(x);
  endfunction

  function automatic logic [ACC_W-1:0] f_neg_acc(input logic signed [ACC_W-1:0] x,
                                                 input logic neg);
    logic signed [ACC_W-1:0] n;
    n = -x;
    return neg ? ACC_W'(n) : ACC_W'(x);
  endfunction

  assign w_div_zero = MDControl && (b == '0);

  // MULT: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
  assign w_mul_sum = {1'b0, r_acc[ACC_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);

  // DIV: acc = {remainder, dividend/quotient}; restoring subtract after left shift.
  assign w_rem_sh = {r_acc[ACC_W-1:DATA_W], r_acc[DATA_W-1]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_mag_b};
  assign w_ge     = ~w_diff[DATA_W+1];

  always_comb begin
    w_step = r_acc;
    if (r_op)
      w_step = {(w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0]), r_acc[DATA_W-2:0], w_ge};
    else
      w_step = {w_mul_sum, r_acc[DATA_W-1:1]};
  end

  always_comb begin
    w_prod   = f_neg_acc(r_acc, r_sign_a ^ r_sign_b);
    w_fix_hi = w_prod[ACC_W-1:DATA_W];
    w_fix_lo = w_prod[DATA_W-1:0];
    if (r_op) begin
      w_fix_hi = f_neg_w(r_acc[ACC_W-1:DATA_W], r_sign_a);
      w_fix_lo = f_neg_w(r_acc[DATA_W-1:0], r_sign_a ^ r_sign_b);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = w_div_zero ? S_DONE : S_ITER;
      S_ITER: if (r_cnt == LAST_ITER) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == S_ITER) || (r_state == S_FIX);
    done    = (r_state == S_DONE);
    divZero = (r_state == S_DONE) && r_dz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dz  <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_op     <= MDControl;
          r_sign_a <= a[DATA_W-1];
          r_sign_b <= b[DATA_W-1];
          r_mag_a  <= f_mag(a);
          r_mag_b  <= f_mag(b);
          r_cnt    <= '0;
          r_dz     <= w_div_zero;
          r_acc    <= {{DATA_W{1'b0}}, (MDControl ? f_mag(a) : f_mag(b))};
        end
        S_ITER: begin
          r_acc <= w_step;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        S_DONE: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: timing of busy/done/divZero, HI/LO results,
// start-while-busy immunity and reset abort.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        reset, start, MDControl;
  logic [31:0] a, b;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_seq #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .MDControl(MDControl),
    .a(a), .b(b), .busy(busy), .done(done), .divZero(divZero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start in the current cycle N and follows the op until cycle N+lat+1.
  task automatic run_op(input string tag, input logic op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int lat, input logic repulse);
    int bad_busy, bad_dz, bad_hold, n_done, done_at;
    bad_busy = 0; bad_dz = 0; bad_hold = 0; n_done = 0; done_at = -1;
    MDControl = op; a = av; b = bv; start = 1'b1;
    step();
    for (int c = 1; c <= lat + 1; c++) begin
      if (busy !== (c < lat)) bad_busy++;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (divZero !== (edz && c == lat)) bad_dz++;
      if (c < lat && (hi !== m_hi || lo !== m_lo)) bad_hold++;
      if (c == lat) begin
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
      end
      start     = repulse && (c == 5);
      MDControl = ~op;
      a         = ~av;
      b         = bv ^ 32'h0000_0005;
      step();
    end
    start = 1'b0;
    chk({tag, "_done_at"}, done_at, lat);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_busy"}, bad_busy, 0);
    chk({tag, "_divzero"}, bad_dz, 0);
    chk({tag, "_hold"}, bad_hold, 0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int bad_busy, n_done;

    // reset with a simultaneous start request
    reset = 1'b1; start = 1'b1; MDControl = 1'b0; a = 32'd5; b = 32'd6;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_divzero", divZero, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b0; start = 1'b0;
    step();
    chk("rst_start_discard", busy, 1'b0);
    step();

    run_op("mul_7_m3",   1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b1);
    run_op("div_100_7",  1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 34, 1'b0);
    run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
    run_op("div_preload",1'b1, 32'h0000_0451,  32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, 34, 1'b0);
    run_op("div_zero",   1'b1, 32'd5,          32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1, 1,  1'b0);
    run_op("mul_min_min",1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, 34, 1'b0);
    run_op("div_min_m1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 34, 1'b0);
    run_op("mul_m5_m6",  1'b0, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 32'h0,         32'd30,        1'b0, 34, 1'b0);
    run_op("div_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34, 1'b0);

    // abort an in-flight MULT with reset at N+10
    bad_busy = 0; n_done = 0;
    MDControl = 1'b0; a = 32'h1234_5678; b = 32'd3; start = 1'b1;
    step();
    for (int c = 1; c <= 11; c++) begin
      if (c <= 10 && busy !== 1'b1) bad_busy++;
      if (done === 1'b1) n_done++;
      if (c == 11) begin
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
      end
      start = (c == 5);
      a     = 32'h0000_0009;
      b     = 32'h0000_0004;
      reset = (c == 10);
      step();
    end
    start = 1'b0; reset = 1'b0;
    chk("abort_busy_run", bad_busy, 0);
    chk("abort_no_done", n_done, 0);
    m_hi = '0;
    m_lo = '0;
    run_op("after_abort", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 Parameter DATA_W, default 32, operand and HI/LO width; only 32 is verified.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 MDControl  input  1  operation select, sampled with start: 0 = signed MULT, 1 = signed DIV.
REQ-006 a  input  DATA_W  rs operand: multiplicand or dividend; sampled with start.
REQ-007 b  input  DATA_W  rt operand: multiplier or divisor; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (ITER, FIX).
REQ-009 done  output  1  one-cycle completion pulse (DONE state).
REQ-010 divZero  output  1  one-cycle pulse coincident with done when DIV had b == 0.
REQ-011 hi  output  DATA_W  HI register: MULT product[63:32] or DIV remainder.
REQ-012 lo  output  DATA_W  LO register: MULT product[31:0] or DIV quotient.

Function
REQ-013 The FSM SHALL have states IDLE, ITER, FIX, DONE; DONE always returns to IDLE on the next cycle.
REQ-014 In IDLE with start = 1 in cycle N, the block SHALL latch MDControl, a, b, the operand signs and the operand magnitudes, then enter ITER at cycle N+1 with a 6-bit iteration counter at 0.
REQ-015 Start SHALL be ignored in ITER, FIX and DONE; no queuing, no effect on the operation in progress.
REQ-016 ITER SHALL last exactly 32 cycles (N+1..N+32), one radix-2 step per cycle, on magnitudes.
REQ-017 MULT step: shift-add on a 64-bit accumulator giving the unsigned 64-bit product of the magnitudes.
REQ-018 DIV step: restoring shift-subtract giving the unsigned 32-bit quotient and remainder of the magnitudes.
REQ-019 FIX (cycle N+33) SHALL apply signs:
  - MULT: 64-bit product negated when the operand signs differ.
  - DIV: quotient negated when the signs differ; remainder takes the sign of the dividend.
REQ-020 hi/lo SHALL update only on the edge entering DONE; done = 1 during cycle N+34.
REQ-021 Between operations and throughout an operation, hi/lo SHALL hold their previous values so MFHI/MFLO read stable data.
REQ-022 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31; 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0 (wrap, no exception).
REQ-023 DIV with b == 0 at start SHALL skip ITER and FIX: DONE in cycle N+1, done = divZero = 1, hi/lo unchanged.
REQ-024 divZero SHALL be 0 in every cycle except that DONE cycle.
REQ-025 busy SHALL be 1 exactly in ITER and FIX, and 0 in IDLE and DONE.
REQ-026 Next start accepted no earlier than cycle N+35 (N+2 after a divide-by-zero).
REQ-027 Arithmetic internal widths: 64-bit accumulator; counter saturates at 32 and never wraps within an operation.

Reset
REQ-028 reset = 1 at a rising edge SHALL force IDLE, busy = 0, done = 0, divZero = 0, hi = 0, lo = 0, counter = 0.
REQ-029 reset SHALL take priority over start and over any in-progress state; an aborted operation produces no done pulse and does not update hi/lo.
REQ-030 start asserted in the same cycle as reset SHALL be discarded.

Verification
REQ-031 MULT a = 7, b = 0xFFFFFFFD (-3), start at N -> busy cycles N+1..N+33, done at N+34, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-032 DIV 100 / 7 -> lo = 14, hi = 2; DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; both done at N+34.
REQ-033 DIV a = 5, b = 0 with hi = 0x11, lo = 0x22 preloaded -> done = divZero = 1 at N+1, hi = 0x11, lo = 0x22, busy never 1.
REQ-034 MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-035 MULT started, start re-pulsed at N+5 with different operands, reset at N+10 -> the N+5 start has no effect, busy = 0 from N+11, hi = lo = 0, no done pulse; new start at N+12 completes normally at N+46.
